// File: rtl/accessor_pkg.sv
// Shared types for the memory-access stage: executor/accessor result bundles,
// FSM state encodings and byte-lane write-strobe base masks.
package accessor_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic        load;
        logic        store;
        mem_size_e   size;
        logic        load_unsigned;
    } executor_output;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        misaligned;
    } accessor_output;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } accessor_state_e;

    localparam logic [3:0] WSTRB_BYTE = 4'b0001;
    localparam logic [3:0] WSTRB_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/accessor_load_extend.sv
// Combinational load lane selection and sign/zero extension of a 32-bit read word.
module load_extend
    import accessor_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{offset_i, 3'b000} +: 8];
        half_v = rdata_i[{offset_i[1], 4'b0000} +: 16];
        case (mem_size_e'(size_i))
            SZ_BYTE: data_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
            SZ_HALF: data_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/accessor.sv
// Memory-access pipeline stage: issues one request/response per load/store,
// encodes store lanes, extends load data and hands results to writeback.
module accessor
    import accessor_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           executor_valid,
    output logic           accessor_ready,
    output logic           accessor_valid,
    input  logic           writeback_ready,
    input  executor_output in,
    output accessor_output out,
    output logic           mem_valid,
    input  logic           mem_ready,
    output logic [31:0]    mem_addr,
    output logic [31:0]    mem_wdata,
    output logic [3:0]     mem_wstrb,
    input  logic [31:0]    mem_rdata
);

    accessor_state_e state_q, state_d;
    accessor_output  out_q, out_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            load_q, load_d;
    mem_size_e       size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      off_q, off_d;

    logic            accept;
    logic            mem_op;
    logic            mis;
    logic [1:0]      lane_off;
    logic [31:0]     ext_data;

    load_extend u_load_extend (
        .rdata_i    (mem_rdata),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    assign accessor_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && writeback_ready);
    assign accept         = executor_valid && accessor_ready;
    assign accessor_valid = (state_q == ST_DONE);
    assign mem_valid      = (state_q == ST_REQ);
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wstrb      = wstrb_q;
    assign out            = out_q;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        load_d   = load_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        mem_op   = in.load || in.store;
        mis      = CHECK_ALIGN && mem_op && is_misaligned(in.size, in.mem_addr[1:0]);

        // Half/word lanes ignore the low address bits that alignment would forbid.
        case (in.size)
            SZ_BYTE: lane_off = in.mem_addr[1:0];
            SZ_HALF: lane_off = {in.mem_addr[1], 1'b0};
            default: lane_off = 2'b00;
        endcase

        case (state_q)
            ST_REQ: begin
                if (mem_ready) begin
                    state_d       = ST_DONE;
                    out_d.rd_data = (load_q && (out_q.rd != 5'd0)) ? ext_data : 32'd0;
                end
            end
            ST_DONE: begin
                if (writeback_ready && !executor_valid) state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            out_d.rd         = in.rd;
            out_d.misaligned = mis;
            out_d.rd_data    = (!mem_op && (in.rd != 5'd0)) ? in.rd_data : 32'd0;
            load_d           = in.load;
            size_d           = in.size;
            uns_d            = in.load_unsigned;
            off_d            = lane_off;
            if (mem_op && !mis) begin
                state_d = ST_REQ;
                addr_d  = {in.mem_addr[31:2], 2'b00};
                wdata_d = 32'd0;
                wstrb_d = 4'b0000;
                if (in.store) begin
                    case (in.size)
                        SZ_BYTE: begin
                            wdata_d = {4{in.mem_data[7:0]}};
                            wstrb_d = WSTRB_BYTE << lane_off;
                        end
                        SZ_HALF: begin
                            wdata_d = {2{in.mem_data[15:0]}};
                            wstrb_d = WSTRB_HALF << lane_off;
                        end
                        default: begin
                            wdata_d = in.mem_data;
                            wstrb_d = WSTRB_WORD;
                        end
                    endcase
                end
            end else begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            load_q  <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            load_q  <= load_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

endmodule
